// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file write arbiter.
// Holds the round-robin priority encoding used by the arbiter and the top.
package regfile_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grants req[0] (A) or req[1] (B), never both.
// The priority flop flips toward the loser after every grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output prio_e      prio
);

    prio_e prio_q;
    prio_e prio_d;

    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & ((prio_q == PRIO_A) | ~req[1]);
        gnt[1] = req[1] & ((prio_q == PRIO_B) | ~req[0]);
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = PRIO_B;
        end else if (gnt[1]) begin
            prio_d = PRIO_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio = prio_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares one register file write port between ALU (A) and load unit (B)
// writebacks, with a registered write stage, forwarding compare and a conflict counter.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       b_data,
    output logic                  Reg_write,
    output logic [REG_ADDR_W-1:0] destination_reg,
    output logic [XLEN-1:0]       write_data,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [XLEN-1:0]       fwd_data,
    output logic [CNT_W-1:0]      conflict_cnt,
    output prio_e                 prio
);

    // Handshake: a request transfers in the cycle its valid and ready are both
    // high; ready is a pure function of both valids and prio, and the
    // requester holds valid/rd/data stable until it sees ready.
    logic [1:0] gnt;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({b_valid, a_valid}),
        .gnt   (gnt),
        .prio  (prio)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        reg_write_d = 1'b0;
        dest_d      = dest_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        if (gnt[0]) begin
            dest_d      = a_rd;
            wdata_d     = a_data;
            reg_write_d = (a_rd != '0);
        end else if (gnt[1]) begin
            dest_d      = b_rd;
            wdata_d     = b_data;
            reg_write_d = (b_rd != '0);
        end
        // Saturate rather than wrap so a long stall never reads as "no conflicts".
        if (a_valid && b_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            dest_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Reg_write       = reg_write_q;
    assign destination_reg = dest_q;
    assign write_data      = wdata_q;
    assign conflict_cnt    = cnt_q;

    assign fwd1_hit = reg_write_q && (dest_q == rs1) && (rs1 != '0);
    assign fwd2_hit = reg_write_q && (dest_q == rs2) && (rs2 != '0);
    assign fwd_data = wdata_q;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of register file write data.
REQ-002 Parameter REG_ADDR_W, default 5, register index width (32 registers).
REQ-003 Parameter CNT_W, default 16, width of the conflict counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a_valid / a_ready / a_rd / a_data  in / out / in / in  1 / 1 / REG_ADDR_W / XLEN  requester A (ALU writeback).
REQ-007 b_valid / b_ready / b_rd / b_data  in / out / in / in  1 / 1 / REG_ADDR_W / XLEN  requester B (load unit writeback).
REQ-008 Reg_write  output  1  register file write enable, registered.
REQ-009 destination_reg  output  REG_ADDR_W  register file write index, registered.
REQ-010 write_data  output  XLEN  register file write data, registered.
REQ-011 rs1, rs2  input  REG_ADDR_W each  current register file read indices.
REQ-012 fwd1_hit, fwd2_hit  output  1 each  in-flight write matches rs1 / rs2.
REQ-013 fwd_data  output  XLEN  data of the in-flight write (equals write_data).
REQ-014 conflict_cnt  output  CNT_W  count of cycles with a_valid and b_valid both high.

Function
REQ-015 The block SHALL arbitrate one register file write port between A and B with round-robin priority state prio in {PRIO_A, PRIO_B}.
REQ-016 a_ready SHALL be 1 iff a_valid and (prio==PRIO_A or !b_valid); b_ready SHALL be 1 iff b_valid and (prio==PRIO_B or !a_valid); both SHALL never be 1 together.
REQ-017 A transfer SHALL occur on a cycle where valid and ready are both high; at most one transfer per cycle.
REQ-018 On a transfer to A, prio SHALL become PRIO_B next cycle; on a transfer to B, prio SHALL become PRIO_A; with no transfer, prio SHALL hold.
REQ-019 Latency: a transfer in cycle N SHALL drive destination_reg/write_data with that request's rd/data in cycle N+1, and Reg_write=1 in N+1 unless rd==0.
REQ-020 A transfer with rd==0 SHALL complete the handshake and update prio, but Reg_write SHALL be 0 in N+1 (x0 write dropped).
REQ-021 With no transfer in cycle N, Reg_write SHALL be 0 in N+1; destination_reg and write_data SHALL hold their previous values.
REQ-022 Requesters SHALL hold valid, rd, data stable until ready; the block need not check this.
REQ-023 fwd1_hit SHALL equal Reg_write and (destination_reg==rs1) and (rs1!=0), combinationally; fwd2_hit likewise for rs2.
REQ-024 fwd_data SHALL equal write_data combinationally.
REQ-025 conflict_cnt SHALL increment by 1 on each cycle with a_valid and b_valid both high and SHALL saturate at all-ones.
REQ-026 No output backpressure exists; the register file accepts one write every cycle.

Reset
REQ-027 reset high SHALL immediately force Reg_write=0, destination_reg=0, write_data=0, conflict_cnt=0, prio=PRIO_A, regardless of clk.
REQ-028 A transfer in the cycle reset asserts SHALL be discarded; no write SHALL emerge after reset deasserts.
REQ-029 a_ready/b_ready SHALL follow REQ-016 using prio=PRIO_A while reset is held; transfers during reset have no effect.

Structure
REQ-030 Package regfile_pkg SHALL hold XLEN, REG_ADDR_W defaults and the prio enumeration type (PRIO_A, PRIO_B).
REQ-031 Round-robin grant logic and the prio state SHALL live in sub-module rr_arbiter2 (inputs req[1:0], outputs gnt[1:0]); the top holds the output register, forwarding compare and counter.

Verification
REQ-032 Reset, then a_valid=1 a_rd=5 a_data=0xDEADBEEF alone -> a_ready=1 same cycle; next cycle Reg_write=1, destination_reg=5, write_data=0xDEADBEEF.
REQ-033 a_valid and b_valid held high 4 cycles (a_rd=1, b_rd=2) from reset -> grants A,B,A,B; destination_reg sequence 1,2,1,2 one cycle later; conflict_cnt=4.
REQ-034 b_valid=1 b_rd=0 b_data=0x1234 -> b_ready=1; next cycle Reg_write=0; prio becomes PRIO_A.
REQ-035 Write to rd=7 in flight with rs1=7, rs2=0 -> fwd1_hit=1, fwd_data=write_data, fwd2_hit=0; with rd=0 write, both hits 0.
REQ-036 Assert reset asynchronously mid-cycle one cycle after a transfer to rd=9 -> Reg_write drops to 0 immediately, no write to 9 after release, prio=PRIO_A.
REQ-037 Force conflict_cnt near saturation (CNT_W=4, 20 contention cycles) -> counter stops at 15.
